// File: rtl/keyboard_inpr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keyboard_inpr                                              |
// | Description : PS/2 scan-code to ASCII input register (INPR/FGI) with a   |
// |               synchronized, edge-detected capture of kbd_flag, a         |
// |               saturating drop counter, and either a single holding       |
// |               register or a FIFO_DEPTH-entry character queue.            |
// | Config      : define KBD_FIFO_EN to build the character queue; without   |
// |               it a single holding register is used and FIFO_DEPTH is     |
// |               unused.                                                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module keyboard_inpr #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_flag,
  input  logic       inp_ack,
  output logic [7:0] inpr,
  output logic       fgi,
  output logic [3:0] drop_count
);

  // Depth must be a power of two in 2..16 (the queue pointers wrap naturally).
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("keyboard_inpr: FIFO_DEPTH must be a power of two in 2..16");
  end

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [1:0] r_warm;
  logic       r_armed;
  logic       w_capture;
  logic [7:0] w_ascii;
  logic       w_mapped;
  logic       w_drop_evt;
  logic [3:0] r_drop;

  // Synchronize kbd_flag, keep the previous value for edge detection, and
  // arm edge detection only once a real low level has been observed, so a
  // flag already high at reset release does not count as a new key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= kbd_flag;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_warm  <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  // r_sync2 only carries a genuinely sampled value once r_warm[1] is set.
  assign w_capture = r_sync2 & ~r_sync3 & r_armed;

  // Scan code to ASCII translation; anything not listed is unmapped.
  always_comb begin
    w_ascii  = 8'h00;
    w_mapped = 1'b1;
    case (kbd_data)
      8'h1C: w_ascii = 8'h41;  8'h32: w_ascii = 8'h42;  8'h21: w_ascii = 8'h43;
      8'h23: w_ascii = 8'h44;  8'h24: w_ascii = 8'h45;  8'h2B: w_ascii = 8'h46;
      8'h34: w_ascii = 8'h47;  8'h33: w_ascii = 8'h48;  8'h43: w_ascii = 8'h49;
      8'h3B: w_ascii = 8'h4A;  8'h42: w_ascii = 8'h4B;  8'h4B: w_ascii = 8'h4C;
      8'h3A: w_ascii = 8'h4D;  8'h31: w_ascii = 8'h4E;  8'h44: w_ascii = 8'h4F;
      8'h4D: w_ascii = 8'h50;  8'h15: w_ascii = 8'h51;  8'h2D: w_ascii = 8'h52;
      8'h1B: w_ascii = 8'h53;  8'h2C: w_ascii = 8'h54;  8'h3C: w_ascii = 8'h55;
      8'h2A: w_ascii = 8'h56;  8'h1D: w_ascii = 8'h57;  8'h22: w_ascii = 8'h58;
      8'h35: w_ascii = 8'h59;  8'h1A: w_ascii = 8'h5A;
      8'h45: w_ascii = 8'h30;  8'h16: w_ascii = 8'h31;  8'h1E: w_ascii = 8'h32;
      8'h26: w_ascii = 8'h33;  8'h25: w_ascii = 8'h34;  8'h2E: w_ascii = 8'h35;
      8'h36: w_ascii = 8'h36;  8'h3D: w_ascii = 8'h37;  8'h3E: w_ascii = 8'h38;
      8'h46: w_ascii = 8'h39;
      8'h29: w_ascii = 8'h20;
      8'h5A: w_ascii = 8'h0D;
      8'h66: w_ascii = 8'h08;
      default: w_mapped = 1'b0;
    endcase
  end

`ifdef KBD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   c_FULL    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign w_pop   = inp_ack & ~w_empty;
  // A push into a full queue still succeeds when the head leaves this cycle.
  assign w_push  = w_capture & w_mapped & ((r_count != c_FULL) | w_pop);
  assign w_drop_evt = w_capture & ~w_push;

  // Queue pointers and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Character storage; contents are only visible while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_ascii;
    end
  end

  assign inpr = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign fgi  = ~w_empty;
`else
  logic [7:0] r_inpr;
  logic       r_fgi;
  logic       w_ack_ok;
  logic       w_load;

  assign w_ack_ok   = inp_ack & r_fgi;
  // The register is free if empty or being read in this same cycle.
  assign w_load     = w_capture & w_mapped & (~r_fgi | w_ack_ok);
  assign w_drop_evt = w_capture & ~w_load;

  // Single holding register: load on accepted capture, clear flag on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inpr <= 8'h00;
      r_fgi  <= 1'b0;
    end else if (w_load) begin
      r_inpr <= w_ascii;
      r_fgi  <= 1'b1;
    end else if (w_ack_ok) begin
      r_fgi  <= 1'b0;
    end
  end

  assign inpr = r_inpr;
  assign fgi  = r_fgi;
`endif

  // Saturating count of discarded characters; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= 4'd0;
    end else if (w_drop_evt && (r_drop != 4'hF)) begin
      r_drop <= r_drop + 4'd1;
    end
  end

  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_inpr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_keyboard_inpr                                           |
// | Description : Directed, table-driven bench for keyboard_inpr. Builds     |
// |               with or without KBD_FIFO_EN.                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_keyboard_inpr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_flag = 1'b0;
  logic       inp_ack = 1'b0;
  logic [7:0] inpr;
  logic       fgi;
  logic [3:0] drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  keyboard_inpr #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .kbd_data   (kbd_data),
    .kbd_flag   (kbd_flag),
    .inp_ack    (inp_ack),
    .inpr       (inpr),
    .fgi        (fgi),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       mapped;
    logic [7:0] ascii;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One key press: flag high for several cycles, then low long enough to re-arm.
  task automatic send(input logic [7:0] code);
    @(negedge clk);
    kbd_data = code;
    kbd_flag = 1'b1;
    repeat (5) @(negedge clk);
    kbd_flag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
  endtask

  int exp_drop;

  initial begin
    vecs[0]  = '{8'h32, 1'b1, 8'h42};
    vecs[1]  = '{8'h4D, 1'b1, 8'h50};
    vecs[2]  = '{8'h1A, 1'b1, 8'h5A};
    vecs[3]  = '{8'h76, 1'b0, 8'h00};
    vecs[4]  = '{8'h45, 1'b1, 8'h30};
    vecs[5]  = '{8'h46, 1'b1, 8'h39};
    vecs[6]  = '{8'hF0, 1'b0, 8'h00};
    vecs[7]  = '{8'h29, 1'b1, 8'h20};
    vecs[8]  = '{8'h5A, 1'b1, 8'h0D};
    vecs[9]  = '{8'h66, 1'b1, 8'h08};
    vecs[10] = '{8'hFF, 1'b0, 8'h00};
    vecs[11] = '{8'h15, 1'b1, 8'h51};

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_inpr", inpr, 8'h00);
    check("reset_fgi", {7'd0, fgi}, 8'h00);
    check("reset_drop", {4'd0, drop_count}, 8'h00);

    // Capture latency: visible just after the 3rd edge sampling the flag high.
    @(negedge clk);
    kbd_data = 8'h1C;
    kbd_flag = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("lat_fgi_edge2", {7'd0, fgi}, 8'h00);
    @(posedge clk);
    #1;
    check("lat_fgi_edge3", {7'd0, fgi}, 8'h01);
    check("lat_inpr_edge3", inpr, 8'h41);
    @(negedge clk);
    kbd_flag = 1'b0;
    inp_ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack_fgi", {7'd0, fgi}, 8'h00);
`ifdef KBD_FIFO_EN
    check("ack_inpr", inpr, 8'h00);
`else
    check("ack_inpr", inpr, 8'h41);
`endif
    @(negedge clk);
    inp_ack = 1'b0;
    repeat (4) @(negedge clk);

    // Table of single presses, acknowledged after each mapped one.
    exp_drop = 0;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].code);
      check($sformatf("vec%0d_fgi", i), {7'd0, fgi}, {7'd0, vecs[i].mapped});
      if (vecs[i].mapped) begin
        check($sformatf("vec%0d_inpr", i), inpr, vecs[i].ascii);
        ack();
      end else begin
        exp_drop++;
      end
      check($sformatf("vec%0d_drop", i), {4'd0, drop_count}, 8'(exp_drop));
    end

    // Saturation of the drop counter.
    for (int i = 0; i < 16; i++) begin
      send(8'h76);
    end
    check("drop_saturate", {4'd0, drop_count}, 8'h0F);
    check("drop_sat_fgi", {7'd0, fgi}, 8'h00);
    do_reset();
    check("drop_cleared", {4'd0, drop_count}, 8'h00);

`ifdef KBD_FIFO_EN
    // Fill a depth-4 queue with one extra, then drain it.
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    send(8'h25);
    send(8'h2E);
    check("fifo_overflow_drop", {4'd0, drop_count}, 8'h01);
    check("fifo_head0", inpr, 8'h31);
    ack();
    check("fifo_head1", inpr, 8'h32);
    ack();
    check("fifo_head2", inpr, 8'h33);
    ack();
    check("fifo_head3", inpr, 8'h34);
    ack();
    check("fifo_empty_fgi", {7'd0, fgi}, 8'h00);
    check("fifo_empty_inpr", inpr, 8'h00);
`else
    // Overrun: second character dropped while the first is unread.
    send(8'h1C);
    send(8'h32);
    check("overrun_inpr", inpr, 8'h41);
    check("overrun_drop", {4'd0, drop_count}, 8'h01);
    // Capture coinciding with an accepted ack is taken.
    @(negedge clk);
    kbd_data = 8'h32;
    kbd_flag = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    inp_ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack_cap_inpr", inpr, 8'h42);
    check("ack_cap_fgi", {7'd0, fgi}, 8'h01);
    check("ack_cap_drop", {4'd0, drop_count}, 8'h01);
    @(negedge clk);
    inp_ack = 1'b0;
    kbd_flag = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // Flag held high for 100 cycles gives exactly one capture.
    do_reset();
    @(negedge clk);
    kbd_data = 8'h1C;
    kbd_flag = 1'b1;
    repeat (100) @(negedge clk);
    check("hold_fgi", {7'd0, fgi}, 8'h01);
    check("hold_inpr", inpr, 8'h41);
    check("hold_drop", {4'd0, drop_count}, 8'h00);
    ack();
    repeat (10) @(negedge clk);
    check("hold_no_recapture", {7'd0, fgi}, 8'h00);
    kbd_flag = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during the synchronizer stages, flag still high at release.
    @(negedge clk);
    kbd_data = 8'h1C;
    kbd_flag = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_fgi", {7'd0, fgi}, 8'h00);
    check("midrst_inpr", inpr, 8'h00);
    check("midrst_drop", {4'd0, drop_count}, 8'h00);
    kbd_flag = 1'b0;
    repeat (4) @(negedge clk);
    send(8'h1C);
    check("after_rst_fgi", {7'd0, fgi}, 8'h01);
    check("after_rst_inpr", inpr, 8'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyboard_inpr.md
KEYBOARD_INPR -- requirements
Module: keyboard_inpr

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, entry count of the character queue; power of two, 2..16; used only when KBD_FIFO_EN is defined.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 kbd_data  input  8  PS/2 scan code from the keyboard interface; asynchronous to clk, stable while kbd_flag is high.
REQ-005 kbd_flag  input  1  keyboard "input arrived" level; asynchronous to clk.
REQ-006 inp_ack  input  1  one-clk CPU pulse: INPR read, clear FGI or pop the queue.
REQ-007 inpr  output  8  ASCII character presented to the CPU (INPR).
REQ-008 fgi  output  1  input flag; high = valid character in inpr.
REQ-009 drop_count  output  4  saturating count of discarded characters (unmapped or overrun).

Function
REQ-010 kbd_flag SHALL pass through a 2-FF synchronizer; a third register SHALL hold the previous synchronized value, and the rising edge (sync2 & ~sync3) SHALL generate one capture event.
REQ-011 A kbd_flag level held high for any duration SHALL produce exactly one capture event.
REQ-012 On a capture event, kbd_data SHALL be sampled and translated combinationally to ASCII in the same cycle.
REQ-013 Translation: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 'A'..'Z' (0x41..0x5A); 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'; 29 -> 0x20; 5A -> 0x0D; 66 -> 0x08.
REQ-014 Any other code, including F0 and FF, SHALL be unmapped: not stored, drop_count incremented.
REQ-015 Capture latency: a mapped character SHALL be visible on inpr with fgi=1 immediately after the 3rd rising clk edge at which kbd_flag is sampled high.
REQ-016 drop_count SHALL saturate at 15 and SHALL be cleared only by reset.
REQ-017 inp_ack while fgi=0 SHALL be ignored.
REQ-018 Without KBD_FIFO_EN there SHALL be a single holding register: a mapped capture while fgi=0 loads inpr and sets fgi.
REQ-019 Without KBD_FIFO_EN, a mapped capture while fgi=1 SHALL be dropped: inpr unchanged, drop_count incremented.
REQ-020 Without KBD_FIFO_EN, inp_ack with fgi=1 SHALL clear fgi on the next edge; inpr SHALL hold its value.
REQ-021 Without KBD_FIFO_EN, a capture coinciding with an accepted inp_ack SHALL be accepted: inpr loads the new character and fgi stays 1.
REQ-022 With KBD_FIFO_EN: circular queue of FIFO_DEPTH entries; inpr = head entry (0x00 when empty); fgi = not empty; inp_ack pops the head.
REQ-023 With KBD_FIFO_EN, a push when full SHALL be dropped and drop_count incremented.
REQ-024 With KBD_FIFO_EN, a simultaneous push and pop when full SHALL both take effect, leaving the occupancy unchanged.
REQ-025 Queue pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a counter one bit wider than the pointers.

Reset
REQ-026 Reset SHALL force: synchronizers 0, inpr=0x00, fgi=0, drop_count=0, queue empty.
REQ-027 Reset asserted mid-capture SHALL discard the in-flight character.
REQ-028 If kbd_flag is already high when reset releases, it SHALL NOT produce a capture; a 0-to-1 transition is required.

Configuration
REQ-029 Macro KBD_FIFO_EN: defined builds the FIFO_DEPTH queue (REQ-022..025); undefined builds the single holding register (REQ-018..021) and FIFO_DEPTH is unused.

Verification
REQ-030 kbd_data=1C, kbd_flag rising -> inpr=0x41, fgi=1 after 3 clk; inp_ack pulse -> fgi=0 next clk.
REQ-031 kbd_data=76 with a flag edge -> fgi stays 0, drop_count=1; 16 unmapped events -> drop_count=15.
REQ-032 No FIFO: 1C then 32 captured, no ack -> inpr=0x41, drop_count=1; ack in the same cycle as the second capture -> inpr=0x42, fgi=1.
REQ-033 FIFO, depth 4: codes 16,1E,26,25,2E, no ack -> drop_count=1; four acks -> inpr reads 0x31,0x32,0x33,0x34, then fgi=0.
REQ-034 kbd_flag held high for 100 clk -> exactly one capture; reset pulse during the synchronizer stages -> fgi=0, inpr=0x00, no capture after release.
